// File: rtl/fifo_sync_param.sv
// Synchronous single-clock FIFO with registered flags, error pulses and an
// optional first-word fall-through read port.
//
// Parameters:
//   WIDTH     data word width in bits
//   DEPTH     number of entries (power of two, >= 2)
//   AF_THRESH almost-full threshold  (count >= AF_THRESH)
//   AE_THRESH almost-empty threshold (count <= AE_THRESH)
//   FWFT      0 = registered read, 1 = first-word fall-through
//
// Ports:
//   clk, rst (async, active high), fifo_clr (sync flush)
//   fifo_wr_en / fifo_wr_data   write request and data
//   fifo_rd_en / fifo_rd_data   read request and data
//   fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty
//   fifo_count                  occupancy, $clog2(DEPTH)+1 bits
//   fifo_wr_err, fifo_rd_err    one-cycle rejected-access pulses
module fifo_sync_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fifo_clr,
  input  logic                       fifo_wr_en,
  input  logic [WIDTH-1:0]           fifo_wr_data,
  input  logic                       fifo_rd_en,
  output logic [WIDTH-1:0]           fifo_rd_data,
  output logic                       fifo_full,
  output logic                       fifo_empty,
  output logic                       fifo_almost_full,
  output logic                       fifo_almost_empty,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       fifo_wr_err,
  output logic                       fifo_rd_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_nxt;
  logic             wr_acc;
  logic             rd_acc;
  logic             wr_rej;
  logic             rd_rej;

  // Acceptance uses the registered flags, so a read in the same cycle
  // never makes room for a write (and vice versa).
  assign wr_acc = fifo_wr_en & ~fifo_full  & ~fifo_clr;
  assign rd_acc = fifo_rd_en & ~fifo_empty & ~fifo_clr;
  assign wr_rej = fifo_wr_en &  fifo_full  & ~fifo_clr;
  assign rd_rej = fifo_rd_en &  fifo_empty & ~fifo_clr;

  always_comb begin
    count_nxt = fifo_count;
    if (fifo_clr) begin
      count_nxt = '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count_nxt = fifo_count + CW'(1);
        2'b01:   count_nxt = fifo_count - CW'(1);
        default: count_nxt = fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (fifo_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Flags are derived from the next count so they line up with
  // fifo_count in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_count        <= '0;
      fifo_full         <= 1'b0;
      fifo_empty        <= 1'b1;
      fifo_almost_full  <= 1'b0;
      fifo_almost_empty <= 1'b1;
    end else begin
      fifo_count        <= count_nxt;
      fifo_full         <= (count_nxt == CW'(DEPTH));
      fifo_empty        <= (count_nxt == '0);
      fifo_almost_full  <= (count_nxt >= CW'(AF_THRESH));
      fifo_almost_empty <= (count_nxt <= CW'(AE_THRESH));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_wr_err <= 1'b0;
      fifo_rd_err <= 1'b0;
    end else begin
      fifo_wr_err <= wr_rej;
      fifo_rd_err <= rd_rej;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= fifo_wr_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head of queue shown directly; forced to zero while empty so the
      // port reads zero during reset.
      assign fifo_rd_data = fifo_empty ? '0 : mem[rd_ptr];
    end else begin : g_reg
      logic [WIDTH-1:0] rd_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_q <= '0;
        end else if (rd_acc) begin
          rd_q <= mem[rd_ptr];
        end
      end
      assign fifo_rd_data = rd_q;
    end
  endgenerate

endmodule
